wb_port_scheduler: RTL and testbench
====================================

Name: wb_port_scheduler

Overview:
- Shares the single register-file write port between three result producers: ALU (single-cycle), memory load unit (variable latency) and FPU (multi-cycle, 64-bit Q15 result).
- Buffers one result per source, arbitrates each cycle, and drives the register write-data mux with a registered select code, held operands, destination address and write enable.
- Sits between the execute/memory stages and the register file write mux.

Parameters:
- MAX_WAIT, 3, cycles an occupied slot may lose arbitration before it is promoted to top priority (1..7).
- AW, 5, register address width.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- alu_valid / alu_ready  in/out  1/1  ALU result handshake.
- alu_rd  in  AW  ALU destination register.
- alu_data  in  32  ALU result.
- mem_valid / mem_ready  in/out  1/1  load result handshake.
- mem_rd  in  AW  load destination register.
- mem_data  in  32  load data.
- fpu_valid / fpu_ready  in/out  1/1  FPU result handshake.
- fpu_rd  in  AW  FPU destination register.
- fpu_fmt  in  2  FPU conversion: 00 u32, 01 i32, 10 fp32, 11 illegal.
- fpu_data  in  64  FPU Q15 result.
- wb_src  out  3  write-source select to the mux: 000 FPU->u32, 001 FPU->i32, 010 ALU, 100 memory, 110 FPU->fp32.
- wb_alu_res  out  32  held ALU operand to the mux.
- wb_mem_data  out  32  held load operand to the mux.
- wb_fpu_res  out  64  held FPU operand to the mux.
- wb_addr  out  AW  register file write address.
- wb_en  out  1  register file write enable, one cycle per write.
- fmt_err  out  1  one-cycle pulse on an illegal fpu_fmt grant.

Behaviour:
- Reset (async, reset_n low): all slots empty, wait counters 0.
  - Outputs: wb_en=0, fmt_err=0, wb_src=3'b010, wb_addr=0, all wb_* data 0.
  - Mid-operation reset drops all pending results and does not pulse wb_en.
- Slots: one entry per source holding {rd, data[, fmt]}.
  - x_ready = slot empty OR slot granted this cycle. Combinational from state only; never depends on x_valid.
  - Accept on the rising edge with x_valid && x_ready; slot loads that edge.
  - Back-to-back accepts on one source sustain 1 result/cycle when that source wins every cycle.
- Arbitration (combinational, among occupied slots):
  - Aged slots (counter == MAX_WAIT) win first.
  - Ties and the non-aged case resolve by base order MEM > FPU > ALU.
  - Exactly one grant per cycle when any slot is occupied.
- Wait counters:
  - An occupied, non-granted slot increments, saturating at MAX_WAIT.
  - The counter clears on grant, and on load into an empty slot.
- Output stage (registered, updated every edge):
  - wb_en <= grant_any && rd != 0 && !illegal. A granted rd == 0 consumes the slot with wb_en=0.
  - wb_addr and wb_src are loaded from the granted slot.
  - Only the granted source's wb_* data register loads; the others hold.
  - FPU fmt maps 00->000, 01->001, 10->110.
  - fmt 11: slot is consumed, wb_en=0, fmt_err=1 for one cycle, wb_src unchanged.
  - No grant: wb_en=0, other outputs hold.
- Latency: accept at edge k into an empty slot with no competitor -> wb_en high in the cycle after edge k+1.
- A grant and a new accept on the same source in one cycle: old entry is written, new entry occupies the slot, counter is 0.
- Write ordering to the same rd across sources is guaranteed by the issuing stage. This block does not reorder within a source.

Test Plan:
- Reset with all valids high -> wb_en=0, wb_src=010, readys low only while reset_n=0; asynchronous assertion clears wb_en mid-cycle.
- Single ALU result rd=5, data=0x1234 accepted edge k -> wb_en=1, wb_addr=5, wb_src=010, wb_alu_res=0x1234 in cycle after edge k+1.
- MEM, FPU (fmt=10) and ALU valid in the same cycle -> writes in order MEM(100), FPU(110), ALU(010) on 3 consecutive cycles; alu_ready low for 2 cycles.
- MEM streams a new result every cycle for 5 cycles while ALU holds one entry, MAX_WAIT=3 -> ALU written after losing exactly 3 arbitrations; MEM stalls one cycle via mem_ready=0.
- FPU rd=0 fmt=00 -> slot consumed, wb_en=0; then FPU rd=7 fmt=11 -> wb_en=0, fmt_err single pulse; then fmt=01 rd=7 -> wb_en=1, wb_src=001.
- ALU continuous valid for 8 cycles with no contention -> 8 writes on 8 consecutive cycles, alu_ready constant 1.

Source files
------------

// File: rtl/wb_port_scheduler.sv
// -----------------------------------------------------------------------------
// wb_port_scheduler
//   Shares the single register-file write port between three result
//   producers: ALU, memory load unit and FPU. Each producer has a one-entry
//   slot. Every cycle one occupied slot is granted. The grant is turned into
//   registered write-mux controls for the next cycle.
//
// Ports
//   clk, reset_n          clock, asynchronous active-low reset
//   alu_valid/ready/rd/data             ALU result handshake and payload
//   mem_valid/ready/rd/data             load result handshake and payload
//   fpu_valid/ready/rd/fmt/data         FPU result handshake and payload (Q15, 64b)
//   wb_src                write-mux select (000 u32, 001 i32, 010 ALU,
//                         100 MEM, 110 fp32)
//   wb_alu_res, wb_mem_data, wb_fpu_res held operands to the write mux
//   wb_addr, wb_en        register-file write address and enable
//   fmt_err               one-cycle pulse when an illegal FPU format is granted
// -----------------------------------------------------------------------------
module wb_port_scheduler #(
    parameter int MAX_WAIT = 3,
    parameter int AW       = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          alu_valid,
    output logic          alu_ready,
    input  logic [AW-1:0] alu_rd,
    input  logic [31:0]   alu_data,
    input  logic          mem_valid,
    output logic          mem_ready,
    input  logic [AW-1:0] mem_rd,
    input  logic [31:0]   mem_data,
    input  logic          fpu_valid,
    output logic          fpu_ready,
    input  logic [AW-1:0] fpu_rd,
    input  logic [1:0]    fpu_fmt,
    input  logic [63:0]   fpu_data,
    output logic [2:0]    wb_src,
    output logic [31:0]   wb_alu_res,
    output logic [31:0]   wb_mem_data,
    output logic [63:0]   wb_fpu_res,
    output logic [AW-1:0] wb_addr,
    output logic          wb_en,
    output logic          fmt_err
);
    localparam logic [2:0] MAX_W   = 3'(MAX_WAIT);
    localparam logic [2:0] SRC_U32 = 3'b000;
    localparam logic [2:0] SRC_I32 = 3'b001;
    localparam logic [2:0] SRC_ALU = 3'b010;
    localparam logic [2:0] SRC_MEM = 3'b100;
    localparam logic [2:0] SRC_F32 = 3'b110;

    // Slot state
    logic          alu_occ_q, alu_occ_d, mem_occ_q, mem_occ_d, fpu_occ_q, fpu_occ_d;
    logic [AW-1:0] alu_rd_q, alu_rd_d, mem_rd_q, mem_rd_d, fpu_rd_q, fpu_rd_d;
    logic [31:0]   alu_data_q, alu_data_d, mem_data_q, mem_data_d;
    logic [63:0]   fpu_data_q, fpu_data_d;
    logic [1:0]    fpu_fmt_q, fpu_fmt_d;
    logic [2:0]    alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d, fpu_cnt_q, fpu_cnt_d;

    // Output registers
    logic [2:0]    wb_src_q, wb_src_d;
    logic [31:0]   wb_alu_res_q, wb_alu_res_d, wb_mem_data_q, wb_mem_data_d;
    logic [63:0]   wb_fpu_res_q, wb_fpu_res_d;
    logic [AW-1:0] wb_addr_q, wb_addr_d;
    logic          wb_en_q, wb_en_d, fmt_err_q, fmt_err_d;

    logic alu_aged, mem_aged, fpu_aged, any_aged;
    logic gnt_alu, gnt_mem, gnt_fpu;
    logic alu_acc, mem_acc, fpu_acc;

    // Arbitration: aged slots form the candidate set when any exist. Within
    // the candidate set, the base order MEM > FPU > ALU applies.
    always_comb begin
        alu_aged = alu_occ_q && (alu_cnt_q == MAX_W);
        mem_aged = mem_occ_q && (mem_cnt_q == MAX_W);
        fpu_aged = fpu_occ_q && (fpu_cnt_q == MAX_W);
        any_aged = alu_aged || mem_aged || fpu_aged;
        if (any_aged) begin
            gnt_mem = mem_aged;
            gnt_fpu = fpu_aged && !mem_aged;
            gnt_alu = alu_aged && !mem_aged && !fpu_aged;
        end else begin
            gnt_mem = mem_occ_q;
            gnt_fpu = fpu_occ_q && !mem_occ_q;
            gnt_alu = alu_occ_q && !mem_occ_q && !fpu_occ_q;
        end
    end

    // A granted slot frees up this edge, so it can take a new entry at the
    // same time. The readys are masked while reset is asserted.
    assign alu_ready = reset_n && (!alu_occ_q || gnt_alu);
    assign mem_ready = reset_n && (!mem_occ_q || gnt_mem);
    assign fpu_ready = reset_n && (!fpu_occ_q || gnt_fpu);

    assign alu_acc = alu_valid && alu_ready;
    assign mem_acc = mem_valid && mem_ready;
    assign fpu_acc = fpu_valid && fpu_ready;

    // Slot update. Any accept lands in an empty or just-granted slot, so the
    // wait counter restarts at 0.
    always_comb begin
        alu_occ_d  = alu_acc || (alu_occ_q && !gnt_alu);
        mem_occ_d  = mem_acc || (mem_occ_q && !gnt_mem);
        fpu_occ_d  = fpu_acc || (fpu_occ_q && !gnt_fpu);
        alu_rd_d   = alu_acc ? alu_rd   : alu_rd_q;
        alu_data_d = alu_acc ? alu_data : alu_data_q;
        mem_rd_d   = mem_acc ? mem_rd   : mem_rd_q;
        mem_data_d = mem_acc ? mem_data : mem_data_q;
        fpu_rd_d   = fpu_acc ? fpu_rd   : fpu_rd_q;
        fpu_data_d = fpu_acc ? fpu_data : fpu_data_q;
        fpu_fmt_d  = fpu_acc ? fpu_fmt  : fpu_fmt_q;

        alu_cnt_d = 3'd0;
        if (!alu_acc && alu_occ_q && !gnt_alu)
            alu_cnt_d = (alu_cnt_q == MAX_W) ? alu_cnt_q : alu_cnt_q + 3'd1;
        mem_cnt_d = 3'd0;
        if (!mem_acc && mem_occ_q && !gnt_mem)
            mem_cnt_d = (mem_cnt_q == MAX_W) ? mem_cnt_q : mem_cnt_q + 3'd1;
        fpu_cnt_d = 3'd0;
        if (!fpu_acc && fpu_occ_q && !gnt_fpu)
            fpu_cnt_d = (fpu_cnt_q == MAX_W) ? fpu_cnt_q : fpu_cnt_q + 3'd1;
    end

    // Output stage. Only the granted source's operand register loads. An
    // illegal FPU format still consumes the slot but leaves wb_src alone.
    always_comb begin
        wb_src_d      = wb_src_q;
        wb_alu_res_d  = wb_alu_res_q;
        wb_mem_data_d = wb_mem_data_q;
        wb_fpu_res_d  = wb_fpu_res_q;
        wb_addr_d     = wb_addr_q;
        wb_en_d       = 1'b0;
        fmt_err_d     = 1'b0;
        if (gnt_mem) begin
            wb_src_d      = SRC_MEM;
            wb_mem_data_d = mem_data_q;
            wb_addr_d     = mem_rd_q;
            wb_en_d       = (mem_rd_q != '0);
        end else if (gnt_fpu) begin
            wb_fpu_res_d = fpu_data_q;
            wb_addr_d    = fpu_rd_q;
            case (fpu_fmt_q)
                2'b00:   wb_src_d = SRC_U32;
                2'b01:   wb_src_d = SRC_I32;
                2'b10:   wb_src_d = SRC_F32;
                default: wb_src_d = wb_src_q;
            endcase
            fmt_err_d = (fpu_fmt_q == 2'b11);
            wb_en_d   = (fpu_rd_q != '0) && (fpu_fmt_q != 2'b11);
        end else if (gnt_alu) begin
            wb_src_d     = SRC_ALU;
            wb_alu_res_d = alu_data_q;
            wb_addr_d    = alu_rd_q;
            wb_en_d      = (alu_rd_q != '0);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_occ_q     <= 1'b0;
            mem_occ_q     <= 1'b0;
            fpu_occ_q     <= 1'b0;
            alu_rd_q      <= '0;
            mem_rd_q      <= '0;
            fpu_rd_q      <= '0;
            alu_data_q    <= '0;
            mem_data_q    <= '0;
            fpu_data_q    <= '0;
            fpu_fmt_q     <= '0;
            alu_cnt_q     <= '0;
            mem_cnt_q     <= '0;
            fpu_cnt_q     <= '0;
            wb_src_q      <= SRC_ALU;
            wb_alu_res_q  <= '0;
            wb_mem_data_q <= '0;
            wb_fpu_res_q  <= '0;
            wb_addr_q     <= '0;
            wb_en_q       <= 1'b0;
            fmt_err_q     <= 1'b0;
        end else begin
            alu_occ_q     <= alu_occ_d;
            mem_occ_q     <= mem_occ_d;
            fpu_occ_q     <= fpu_occ_d;
            alu_rd_q      <= alu_rd_d;
            mem_rd_q      <= mem_rd_d;
            fpu_rd_q      <= fpu_rd_d;
            alu_data_q    <= alu_data_d;
            mem_data_q    <= mem_data_d;
            fpu_data_q    <= fpu_data_d;
            fpu_fmt_q     <= fpu_fmt_d;
            alu_cnt_q     <= alu_cnt_d;
            mem_cnt_q     <= mem_cnt_d;
            fpu_cnt_q     <= fpu_cnt_d;
            wb_src_q      <= wb_src_d;
            wb_alu_res_q  <= wb_alu_res_d;
            wb_mem_data_q <= wb_mem_data_d;
            wb_fpu_res_q  <= wb_fpu_res_d;
            wb_addr_q     <= wb_addr_d;
            wb_en_q       <= wb_en_d;
            fmt_err_q     <= fmt_err_d;
        end
    end

    assign wb_src      = wb_src_q;
    assign wb_alu_res  = wb_alu_res_q;
    assign wb_mem_data = wb_mem_data_q;
    assign wb_fpu_res  = wb_fpu_res_q;
    assign wb_addr     = wb_addr_q;
    assign wb_en       = wb_en_q;
    assign fmt_err     = fmt_err_q;
endmodule

// File: tb/tb_wb_port_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wb_port_scheduler
//   Directed bench for wb_port_scheduler. Inputs are driven on the falling
//   edge. Registered outputs and readys are sampled on the falling edge,
//   before new inputs are applied.
// -----------------------------------------------------------------------------
module tb_wb_port_scheduler;
    localparam int AW = 5;

    logic          clk, reset_n;
    logic          alu_valid, alu_ready, mem_valid, mem_ready, fpu_valid, fpu_ready;
    logic [AW-1:0] alu_rd, mem_rd, fpu_rd, wb_addr;
    logic [31:0]   alu_data, mem_data, wb_alu_res, wb_mem_data;
    logic [1:0]    fpu_fmt;
    logic [63:0]   fpu_data, wb_fpu_res;
    logic [2:0]    wb_src;
    logic          wb_en, fmt_err;

    int n_compared   = 0;
    int n_mismatched = 0;

    wb_port_scheduler #(.MAX_WAIT(3), .AW(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .fpu_valid(fpu_valid), .fpu_ready(fpu_ready), .fpu_rd(fpu_rd), .fpu_fmt(fpu_fmt),
        .fpu_data(fpu_data),
        .wb_src(wb_src), .wb_alu_res(wb_alu_res), .wb_mem_data(wb_mem_data),
        .wb_fpu_res(wb_fpu_res), .wb_addr(wb_addr), .wb_en(wb_en), .fmt_err(fmt_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_wb(input string tag, input logic [2:0] src, input logic [AW-1:0] addr);
        check_val({tag, ".wb_en"},   64'(wb_en), 64'd1);
        check_val({tag, ".wb_src"},  64'(wb_src), 64'(src));
        check_val({tag, ".wb_addr"}, 64'(wb_addr), 64'(addr));
    endtask

    initial begin
        reset_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 5'd1; alu_data = 32'hAAAA;
        mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 32'hBBBB;
        fpu_valid = 1'b1; fpu_rd = 5'd3; fpu_fmt = 2'b10; fpu_data = 64'hCCCC;

        // Reset held with all valids high
        tick(); tick();
        check_val("rst.wb_en", 64'(wb_en), 64'd0);
        check_val("rst.wb_src", 64'(wb_src), 64'b010);
        check_val("rst.wb_addr", 64'(wb_addr), 64'd0);
        check_val("rst.fmt_err", 64'(fmt_err), 64'd0);
        check_val("rst.readys", 64'({alu_ready, mem_ready, fpu_ready}), 64'd0);
        alu_valid = 1'b0; mem_valid = 1'b0; fpu_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        check_val("rst.readys_rel", 64'({alu_ready, mem_ready, fpu_ready}), 64'b111);
        tick();
        check_val("rst.no_write", 64'(wb_en), 64'd0);

        // Single ALU result: accepted at the next edge, written one edge later
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234;
        tick();
        alu_valid = 1'b0;
        check_val("alu1.wb_en_early", 64'(wb_en), 64'd0);
        tick();
        check_wb("alu1", 3'b010, 5'd5);
        check_val("alu1.res", 64'(wb_alu_res), 64'h1234);
        tick();
        check_val("alu1.wb_en_after", 64'(wb_en), 64'd0);

        // Three sources at once: MEM, FPU, ALU order
        mem_valid = 1'b1; mem_rd = 5'd1; mem_data = 32'hDEAD0001;
        fpu_valid = 1'b1; fpu_rd = 5'd2; fpu_fmt = 2'b10; fpu_data = 64'h0123_4567_89AB_CDEF;
        alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h0000_0333;
        tick();
        mem_valid = 1'b0; fpu_valid = 1'b0; alu_valid = 1'b0;
        check_val("tri.alu_ready_c1", 64'(alu_ready), 64'd0);
        tick();
        check_wb("tri.mem", 3'b100, 5'd1);
        check_val("tri.mem_data", 64'(wb_mem_data), 64'hDEAD0001);
        check_val("tri.alu_ready_c2", 64'(alu_ready), 64'd0);
        tick();
        check_wb("tri.fpu", 3'b110, 5'd2);
        check_val("tri.fpu_res", wb_fpu_res, 64'h0123_4567_89AB_CDEF);
        check_val("tri.alu_ready_c3", 64'(alu_ready), 64'd1);
        tick();
        check_wb("tri.alu", 3'b010, 5'd3);
        check_val("tri.alu_res", 64'(wb_alu_res), 64'h333);
        tick();
        check_val("tri.idle", 64'(wb_en), 64'd0);

        // Aging: ALU waits while MEM streams; ALU wins after 3 lost rounds
        alu_valid = 1'b1; alu_rd = 5'd4; alu_data = 32'hA1A1;
        mem_valid = 1'b1; mem_rd = 5'd6; mem_data = 32'h100;
        tick();
        alu_valid = 1'b0; mem_data = 32'h101;
        check_val("age.wb_en0", 64'(wb_en), 64'd0);
        tick();
        check_wb("age.m0", 3'b100, 5'd6);
        check_val("age.m0_data", 64'(wb_mem_data), 64'h100);
        mem_data = 32'h102;
        tick();
        check_val("age.m1_data", 64'(wb_mem_data), 64'h101);
        mem_data = 32'h103;
        tick();
        check_val("age.m2_data", 64'(wb_mem_data), 64'h102);
        check_val("age.mem_stall", 64'(mem_ready), 64'd0);
        mem_data = 32'h104;
        tick();
        check_wb("age.alu", 3'b010, 5'd4);
        check_val("age.alu_res", 64'(wb_alu_res), 64'hA1A1);
        check_val("age.mem_ready_back", 64'(mem_ready), 64'd1);
        tick();
        mem_valid = 1'b0;
        check_wb("age.m3", 3'b100, 5'd6);
        check_val("age.m3_data", 64'(wb_mem_data), 64'h103);
        tick();
        check_val("age.m4_data", 64'(wb_mem_data), 64'h104);
        check_val("age.m4_en", 64'(wb_en), 64'd1);
        tick();
        check_val("age.idle", 64'(wb_en), 64'd0);

        // FPU rd=0, then illegal format, then i32
        fpu_valid = 1'b1; fpu_rd = 5'd0; fpu_fmt = 2'b00; fpu_data = 64'h1111;
        tick();
        fpu_valid = 1'b0;
        tick();
        check_val("fpu0.wb_en", 64'(wb_en), 64'd0);
        check_val("fpu0.wb_src", 64'(wb_src), 64'b000);
        check_val("fpu0.res", wb_fpu_res, 64'h1111);
        check_val("fpu0.ready", 64'(fpu_ready), 64'd1);
        fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_fmt = 2'b11; fpu_data = 64'h2222;
        tick();
        fpu_valid = 1'b0;
        check_val("fpu_ill.err_early", 64'(fmt_err), 64'd0);
        tick();
        check_val("fpu_ill.wb_en", 64'(wb_en), 64'd0);
        check_val("fpu_ill.fmt_err", 64'(fmt_err), 64'd1);
        check_val("fpu_ill.wb_src_held", 64'(wb_src), 64'b000);
        fpu_valid = 1'b1; fpu_rd = 5'd7; fpu_fmt = 2'b01; fpu_data = 64'h3333;
        tick();
        fpu_valid = 1'b0;
        check_val("fpu_ill.err_pulse_end", 64'(fmt_err), 64'd0);
        tick();
        check_wb("fpu_i32", 3'b001, 5'd7);
        check_val("fpu_i32.res", wb_fpu_res, 64'h3333);
        check_val("fpu_i32.fmt_err", 64'(fmt_err), 64'd0);
        tick();

        // ALU streaming: 8 writes on 8 consecutive cycles
        for (int i = 0; i < 10; i++) begin
            if (i >= 2) begin
                check_val($sformatf("stream%0d.wb_en", i - 2), 64'(wb_en), 64'd1);
                check_val($sformatf("stream%0d.res", i - 2), 64'(wb_alu_res), 64'(32'h5000 + i - 2));
            end
            if (i < 8) begin
                check_val($sformatf("stream%0d.ready", i), 64'(alu_ready), 64'd1);
                alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'h5000 + 32'(i);
            end else begin
                alu_valid = 1'b0;
            end
            tick();
        end
        check_val("stream.idle", 64'(wb_en), 64'd0);

        // Mid-operation reset: clears wb_en at once and drops the pending ALU entry
        mem_valid = 1'b1; mem_rd = 5'd8; mem_data = 32'h77;
        alu_valid = 1'b1; alu_rd = 5'd10; alu_data = 32'h88;
        tick();
        mem_valid = 1'b0; alu_valid = 1'b0;
        tick();
        check_wb("mrst.mem", 3'b100, 5'd8);
        reset_n = 1'b0;
        #1;
        check_val("mrst.wb_en_async", 64'(wb_en), 64'd0);
        check_val("mrst.wb_src", 64'(wb_src), 64'b010);
        check_val("mrst.alu_ready", 64'(alu_ready), 64'd0);
        tick();
        reset_n = 1'b1;
        tick();
        check_val("mrst.dropped1", 64'(wb_en), 64'd0);
        tick();
        check_val("mrst.dropped2", 64'(wb_en), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
